operand_fetch_ctrl: RTL

- Initiator-side controller for the 32x32 integer register file.
- Accepts RV32I instruction words, decodes source/destination fields and drives the register file read addresses, then registers the operands for the execute stage.
- Tracks in-flight destination registers in a scoreboard to stall on RAW/WAW hazards.
- Drives the register file write port from the writeback bus.

---
 rtl/operand_fetch_ctrl_pkg.sv | 44 ++++
 rtl/operand_fetch_ctrl_decode.sv | 45 ++++
 rtl/operand_fetch_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared definitions for the operand fetch controller: widths, RV32I opcodes,
// FSM state encoding and the operand bundle payload.
package operand_fetch_ctrl_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPC_W      = 7;

    localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    typedef struct packed {
        logic                  uses_rs1;
        logic                  uses_rs2;
        logic                  writes_rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } dec_t;

    typedef struct packed {
        logic [INSTR_W-1:0]    instr;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [REG_ADDR_W-1:0] rd;
    } op_bundle_t;

endpackage

// File: rtl/operand_fetch_ctrl_decode.sv
// Combinational RV32I field decode: which operands an instruction reads and
// whether it writes a destination register.
module opfetch_decode
    import operand_fetch_ctrl_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output dec_t               o_dec
);

    logic [OPC_W-1:0] w_opc;
    logic             w_unused;

    assign w_opc    = i_instr[6:0];
    assign w_unused = &{1'b0, i_instr[31:25], i_instr[14:12]};

    // Opcode class decode; unknown opcodes read and write nothing.
    always_comb begin
        o_dec           = '0;
        o_dec.rs1       = i_instr[19:15];
        o_dec.rs2       = i_instr[24:20];
        o_dec.rd        = i_instr[11:7];
        case (w_opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                o_dec.writes_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                o_dec.uses_rs1  = 1'b1;
                o_dec.writes_rd = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                o_dec.uses_rs1  = 1'b1;
                o_dec.uses_rs2  = 1'b1;
            end
            OPC_OP: begin
                o_dec.uses_rs1  = 1'b1;
                o_dec.uses_rs2  = 1'b1;
                o_dec.writes_rd = 1'b1;
            end
            default: begin
                o_dec.uses_rs1  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: decodes instructions, reads the register file,
// stalls on RAW/WAW hazards via a busy scoreboard and registers operand bundles.
// Optional writeback forwarding is enabled by defining OPFETCH_WB_FWD_EN.
module operand_fetch_ctrl
    import operand_fetch_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [INSTR_W-1:0]    instr_i,
    output logic [REG_ADDR_W-1:0] rf_rs1_addr_o,
    output logic [REG_ADDR_W-1:0] rf_rs2_addr_o,
    input  logic [XLEN-1:0]       rf_rs1_data_i,
    input  logic [XLEN-1:0]       rf_rs2_data_i,
    output logic                  rf_wr_en_o,
    output logic [REG_ADDR_W-1:0] rf_rd_addr_o,
    output logic [XLEN-1:0]       rf_wr_data_o,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_addr_i,
    input  logic [XLEN-1:0]       wb_data_i,
    output logic                  op_valid_o,
    input  logic                  op_ready_i,
    output logic [INSTR_W-1:0]    op_instr_o,
    output logic [XLEN-1:0]       op_rs1_data_o,
    output logic [XLEN-1:0]       op_rs2_data_o,
    output logic [REG_ADDR_W-1:0] op_rd_o
);

    dec_t            w_dec;
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    out_state_e      r_state;
    out_state_e      w_state_nxt;
    op_bundle_t      r_bundle;
    op_bundle_t      w_bundle_nxt;

    logic            w_wb_fire;
    logic            w_fwd_rs1;
    logic            w_fwd_rs2;
    logic            w_fwd_rd;
    logic            w_haz_rs1;
    logic            w_haz_rs2;
    logic            w_haz_rd;
    logic            w_hazard;
    logic            w_issue;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    opfetch_decode u_decode (
        .i_instr (instr_i),
        .o_dec   (w_dec)
    );

    assign w_wb_fire = wb_valid_i && (wb_addr_i != '0);

`ifdef OPFETCH_WB_FWD_EN
    assign w_fwd_rs1 = w_wb_fire && w_dec.uses_rs1 && (wb_addr_i == w_dec.rs1);
    assign w_fwd_rs2 = w_wb_fire && w_dec.uses_rs2 && (wb_addr_i == w_dec.rs2);
    assign w_fwd_rd  = w_wb_fire && (wb_addr_i == w_dec.rd);
`else
    assign w_fwd_rs1 = 1'b0;
    assign w_fwd_rs2 = 1'b0;
    assign w_fwd_rd  = 1'b0;
`endif

    // Hazard detection against the in-flight destination scoreboard.
    assign w_haz_rs1 = w_dec.uses_rs1 && r_busy[w_dec.rs1] && !w_fwd_rs1;
    assign w_haz_rs2 = w_dec.uses_rs2 && r_busy[w_dec.rs2] && !w_fwd_rs2;
    assign w_haz_rd  = w_dec.writes_rd && (w_dec.rd != '0) && r_busy[w_dec.rd] && !w_fwd_rd;
    assign w_hazard  = w_haz_rs1 || w_haz_rs2 || w_haz_rd;

    assign instr_ready_o = !w_hazard && ((r_state == ST_EMPTY) || op_ready_i);
    assign w_issue       = instr_valid_i && instr_ready_o;

    assign rf_rs1_addr_o = w_dec.uses_rs1 ? w_dec.rs1 : '0;
    assign rf_rs2_addr_o = w_dec.uses_rs2 ? w_dec.rs2 : '0;
    assign w_rs1_data    = w_fwd_rs1 ? wb_data_i : rf_rs1_data_i;
    assign w_rs2_data    = w_fwd_rs2 ? wb_data_i : rf_rs2_data_i;

    // Writeback is a straight pass-through to the register file port.
    assign rf_wr_en_o   = w_wb_fire;
    assign rf_rd_addr_o = wb_addr_i;
    assign rf_wr_data_o = wb_data_i;

    // Scoreboard update: writeback clears, issue sets; set wins on collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_fire) begin
            w_busy_nxt[wb_addr_i] = 1'b0;
        end
        if (w_issue && w_dec.writes_rd && (w_dec.rd != '0)) begin
            w_busy_nxt[w_dec.rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Output stage next-state and bundle load; bundle is held while stalled.
    always_comb begin
        w_state_nxt  = r_state;
        w_bundle_nxt = r_bundle;
        case (r_state)
            ST_EMPTY: begin
                if (w_issue) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_issue) begin
                    w_state_nxt = ST_FULL;
                end else if (op_ready_i) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (w_issue) begin
            w_bundle_nxt.instr    = instr_i;
            w_bundle_nxt.rs1_data = w_rs1_data;
            w_bundle_nxt.rs2_data = w_rs2_data;
            w_bundle_nxt.rd       = w_dec.writes_rd ? w_dec.rd : '0;
        end
    end

    // State, bundle and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_bundle <= '0;
            r_busy   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_bundle <= w_bundle_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign op_valid_o    = (r_state == ST_FULL);
    assign op_instr_o    = r_bundle.instr;
    assign op_rs1_data_o = r_bundle.rs1_data;
    assign op_rs2_data_o = r_bundle.rs2_data;
    assign op_rd_o       = r_bundle.rd;

endmodule
